// File: rtl/weight_load_ctrl.sv
// Weight buffer reload sequencer: streams TOTAL twiddle words from ROM, highest address first,
// into a shift-in weight buffer so that address 0 ends up in the lowest slot.
module weight_load_ctrl #(
    parameter int NPOINT = 3,
    parameter int WIDTH  = 16,
    localparam int TOTAL  = NPOINT * (2 ** (NPOINT - 1)),
    localparam int ADDR_W = ($clog2(TOTAL) < 1) ? 1 : $clog2(TOTAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data_real,
    input  logic [WIDTH-1:0]  rom_data_imag,
    output logic              din_weight_valid,
    output logic [WIDTH-1:0]  din_weight_real,
    output logic [WIDTH-1:0]  din_weight_imag,
    output logic              busy,
    output logic              done,
    output logic              loaded
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(TOTAL - 1);

    state_e             state_q;
    logic               rom_en_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               dv_q;
    logic [WIDTH-1:0]   dr_q;
    logic [WIDTH-1:0]   di_q;
    logic               busy_q;
    logic               done_q;
    logic               loaded_q;

    // rom_addr_q doubles as the issue counter: it always holds the last issued address,
    // so the load ends when address 0 has been issued and can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            dv_q       <= 1'b0;
            dr_q       <= '0;
            di_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            rom_en_q <= 1'b0;
            done_q   <= 1'b0;
            dv_q     <= rom_en_q;
            if (rom_en_q) begin
                dr_q <= rom_data_real;
                di_q <= rom_data_imag;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StFetch;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= AddrLast;
                        busy_q     <= 1'b1;
                        loaded_q   <= 1'b0;
                    end
                end
                StFetch: begin
                    if (rom_en_q && (rom_addr_q == '0)) begin
                        state_q <= StDrain;
                    end else if (!stall) begin
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= rom_addr_q - ADDR_W'(1);
                    end
                end
                StDrain: begin
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    loaded_q <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rom_en           = rom_en_q;
    assign rom_addr         = rom_addr_q;
    assign din_weight_valid = dv_q;
    assign din_weight_real  = dr_q;
    assign din_weight_imag  = di_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign loaded           = loaded_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: default instance under directed and random loads,
// plus a NPOINT=1 instance for the single-word corner.
module tb_weight_load_ctrl;

    localparam int W     = 16;
    localparam int TOTAL = 12;
    localparam int AW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stall, start_b;
    logic          rom_en, din_valid, busy, done, loaded;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_real, rom_imag, din_real, din_imag;
    logic          rom_en_b, din_valid_b, busy_b, done_b, loaded_b;
    logic [0:0]    rom_addr_b;
    logic [W-1:0]  rom_real_b, rom_imag_b, din_real_b, din_imag_b;

    // ROM word(a) = {a+0x100, a+0x200}, read asynchronously from the registered address.
    assign rom_real   = 16'h0100 + {12'd0, rom_addr};
    assign rom_imag   = 16'h0200 + {12'd0, rom_addr};
    assign rom_real_b = 16'h0100 + {15'd0, rom_addr_b};
    assign rom_imag_b = 16'h0200 + {15'd0, rom_addr_b};

    weight_load_ctrl #(.NPOINT(3), .WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data_real(rom_real), .rom_data_imag(rom_imag),
        .din_weight_valid(din_valid), .din_weight_real(din_real), .din_weight_imag(din_imag),
        .busy(busy), .done(done), .loaded(loaded)
    );

    weight_load_ctrl #(.NPOINT(1), .WIDTH(W)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(1'b0),
        .rom_en(rom_en_b), .rom_addr(rom_addr_b),
        .rom_data_real(rom_real_b), .rom_data_imag(rom_imag_b),
        .din_weight_valid(din_valid_b), .din_weight_real(din_real_b),
        .din_weight_imag(din_imag_b),
        .busy(busy_b), .done(done_b), .loaded(loaded_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    int         exp_addr[$];
    int         exp_word[$];
    int         exp_done[$];
    logic [W-1:0] buf_r[TOTAL];
    logic [W-1:0] buf_i[TOTAL];
    bit         mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        int a;
        if (mon_en) begin
            if (rom_en) begin
                if (exp_addr.size() == 0) check("rom_en_extra", {31'd0, rom_en}, 32'd0);
                else check("rom_addr", {28'd0, rom_addr}, exp_addr.pop_front());
            end
            if (din_valid) begin
                if (exp_word.size() == 0) begin
                    check("strobe_extra", {31'd0, din_valid}, 32'd0);
                end else begin
                    a = exp_word.pop_front();
                    check("din_real", {16'd0, din_real}, 32'h100 + a);
                    check("din_imag", {16'd0, din_imag}, 32'h200 + a);
                end
                for (int i = TOTAL - 1; i > 0; i--) begin
                    buf_r[i] = buf_r[i-1];
                    buf_i[i] = buf_i[i-1];
                end
                buf_r[0] = din_real;
                buf_i[0] = din_imag;
            end
            if (done) begin
                if (exp_done.size() == 0) check("done_extra", {31'd0, done}, 32'd0);
                else check("done_cycle", cyc, exp_done.pop_front());
                check("loaded_at_done", {31'd0, loaded}, 32'd1);
                check("busy_at_done", {31'd0, busy}, 32'd0);
                for (int i = 0; i < TOTAL; i++) begin
                    check($sformatf("buf_real[%0d]", i), {16'd0, buf_r[i]}, 32'h100 + i);
                    check($sformatf("buf_imag[%0d]", i), {16'd0, buf_i[i]}, 32'h200 + i);
                end
            end
            if (busy) check("loaded_while_busy", {31'd0, loaded}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input int done_abs);
        for (int a = TOTAL - 1; a >= 0; a--) begin
            exp_addr.push_back(a);
            exp_word.push_back(a);
        end
        exp_done.push_back(done_abs);
    endtask

    // Relative cycle 0 carries the start pulse. A fetch is issued in cycle 1, then in each
    // later cycle whose preceding cycle had stall low; done comes two cycles after the last.
    task automatic run_load(input bit rnd, input int st_lo, input int st_hi, input int done_fix);
        bit st[200];
        int issues, c, done_rel, t0;
        for (int k = 0; k < 200; k++)
            st[k] = rnd ? ($urandom_range(0, 2) == 0) : (k >= st_lo && k <= st_hi);
        if (done_fix >= 0) begin
            done_rel = done_fix;
        end else begin
            issues = 1;
            c = 1;
            while (issues < TOTAL && c < 190) begin
                c++;
                if (!st[c-1]) issues++;
            end
            done_rel = c + 2;
        end
        t0 = cyc;
        push_load(t0 + done_rel);
        for (int r = 0; r <= done_rel + 1; r++) begin
            if (r == 0) start = 1'b1;
            else if (rnd && r <= done_rel) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            stall = st[r];
            tick();
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rom_en"}, {31'd0, rom_en}, 32'd0);
        check({tag, "_rom_addr"}, {28'd0, rom_addr}, 32'd0);
        check({tag, "_din_valid"}, {31'd0, din_valid}, 32'd0);
        check({tag, "_din_real"}, {16'd0, din_real}, 32'd0);
        check({tag, "_din_imag"}, {16'd0, din_imag}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : stimulus
        int t0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; start_b = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            buf_r[i] = '0;
            buf_i[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");
        check("reset_b_loaded", {31'd0, loaded_b}, 32'd0);
        check("reset_b_busy", {31'd0, busy_b}, 32'd0);
        mon_en = 1'b1;

        // Single-word load on the NPOINT=1 instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_rom_en_c1", {31'd0, rom_en_b}, 32'd1);
        check("b_rom_addr_c1", {31'd0, rom_addr_b}, 32'd0);
        check("b_busy_c1", {31'd0, busy_b}, 32'd1);
        tick();
        check("b_strobe_c2", {31'd0, din_valid_b}, 32'd1);
        check("b_real_c2", {16'd0, din_real_b}, 32'h100);
        check("b_imag_c2", {16'd0, din_imag_b}, 32'h200);
        check("b_rom_en_c2", {31'd0, rom_en_b}, 32'd0);
        tick();
        check("b_done_c3", {31'd0, done_b}, 32'd1);
        check("b_loaded_c3", {31'd0, loaded_b}, 32'd1);
        check("b_strobe_c3", {31'd0, din_valid_b}, 32'd0);
        tick();
        check("b_done_c4", {31'd0, done_b}, 32'd0);
        check("b_loaded_c4", {31'd0, loaded_b}, 32'd1);
        check("b_busy_c4", {31'd0, busy_b}, 32'd0);

        run_load(1'b0, 1, 0, 14);
        run_load(1'b0, 3, 5, 17);

        // start held for 40 cycles: loads every 15 cycles, one IDLE cycle between them.
        t0 = cyc;
        push_load(t0 + 14);
        push_load(t0 + 29);
        push_load(t0 + 44);
        start = 1'b1;
        repeat (40) tick();
        start = 1'b0;
        repeat (8) tick();

        // Reset during cycle 6 of a load, then a fresh load from cycle 10.
        t0 = cyc;
        for (int a = TOTAL - 1; a >= 0; a--) begin
            exp_addr.push_back(a);
            exp_word.push_back(a);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("words_left_at_rst", exp_word.size(), 32'd7);
        check("addrs_left_at_rst", exp_addr.size(), 32'd6);
        exp_word.delete();
        exp_addr.delete();
        check_reset_state("abort");
        repeat (3) tick();
        push_load(t0 + 24);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();

        repeat (4) run_load(1'b1, 0, 0, -1);
        repeat (3) tick();

        check("pending_addr", exp_addr.size(), 32'd0);
        check("pending_words", exp_word.size(), 32'd0);
        check("pending_done", exp_done.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter NPOINT, default 3, meaning log2 of FFT point count.
REQ-002 SHALL have parameter WIDTH, default 16, meaning bit width of one weight component (real or imag).
REQ-003 SHALL derive localparam TOTAL = NPOINT*2**(NPOINT-1) (12 at defaults) and ADDR_W = clog2(TOTAL), minimum 1 (4 at defaults).
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have start  input  1  request full reload of the weight buffer.
REQ-007 SHALL have stall  input  1  pause ROM fetch issue.
REQ-008 SHALL have rom_en  output  1  ROM read enable.
REQ-009 SHALL have rom_addr  output  ADDR_W  ROM read address.
REQ-010 SHALL have rom_data_real  input  WIDTH  ROM real word, valid the cycle after rom_en.
REQ-011 SHALL have rom_data_imag  input  WIDTH  ROM imag word, same timing.
REQ-012 SHALL have din_weight_valid  output  1  shift strobe to the weight buffer.
REQ-013 SHALL have din_weight_real / din_weight_imag  output  WIDTH each  weight words to the buffer.
REQ-014 SHALL have busy  output  1  load in progress.
REQ-015 SHALL have done  output  1  one-cycle completion pulse.
REQ-016 SHALL have loaded  output  1  buffer holds a complete, current weight set.

Function
REQ-017 SHALL be an FSM with states IDLE, FETCH, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: start=1 -> FETCH, issue counter = TOTAL-1, loaded cleared next cycle; start=0 -> stay.
REQ-019 FETCH: per cycle with stall sampled 0, drive rom_en=1, rom_addr=counter in the next cycle, then decrement; address sequence TOTAL-1 down to 0, so address 0 lands in the buffer's lowest slot.
REQ-020 FETCH: stall sampled 1 -> rom_en=0 next cycle, counter and rom_addr held; no words skipped or repeated.
REQ-021 FETCH -> DRAIN after issuing address 0; DRAIN lasts exactly one cycle to capture the last ROM word.
REQ-022 din_weight_valid SHALL equal rom_en delayed one cycle; din_weight_real/imag SHALL register rom_data_real/imag in that same cycle and hold otherwise.
REQ-023 Exactly TOTAL din_weight_valid pulses per load; never more, never fewer.
REQ-024 DRAIN -> DONE; DONE drives done=1 and loaded=1 for one cycle, then -> IDLE; loaded stays 1 until next accepted start or reset.
REQ-025 Unstalled timing, start high in cycle 0: rom_en cycles 1..TOTAL, din_weight_valid cycles 2..TOTAL+1, done and loaded rise in cycle TOTAL+2; busy high cycles 1..TOTAL+1.
REQ-026 start while busy or in DONE SHALL be ignored (not queued).
REQ-027 stall in IDLE, DRAIN, DONE SHALL have no effect.
REQ-028 counter SHALL never wrap below 0; rom_addr never exceeds TOTAL-1.

Reset
REQ-029 rst=1 at a clock edge -> next cycle: IDLE, rom_en=0, rom_addr=0, din_weight_valid=0, din_weight_real/imag=0, busy=0, done=0, loaded=0.
REQ-030 rst mid-load SHALL abort without further din_weight_valid pulses, including the in-flight ROM word; loaded remains 0.
REQ-031 rst takes priority over start and stall in the same cycle.

Verification
REQ-032 Defaults, ROM word(a) = {real=a+0x100, imag=a+0x200}, start pulse cycle 0, stall=0 -> rom_addr 11..0 in cycles 1..12; 12 valid strobes cycles 2..13, first real=0x10B, last real=0x100; done=1 only in cycle 14.
REQ-033 Same with stall=1 in cycles 3..5 -> rom_en low in cycles 4..6, address sequence unbroken, exactly 12 strobes, done in cycle 17.
REQ-034 start held high continuously 40 cycles -> loads run back-to-back with one IDLE cycle between; each load 12 strobes, one done each; no start accepted while busy=1.
REQ-035 rst asserted in cycle 6 of a load -> from cycle 7 no strobes, busy=0, loaded=0; new start in cycle 10 -> full 12-word load, done in cycle 24.
REQ-036 NPOINT=1 (TOTAL=1, ADDR_W=1) -> one rom_en with addr 0, one strobe in cycle 2, done in cycle 3.
REQ-037 Scoreboard on all tests: model the shift buffer and compare final contents to ROM contents, slot i = word(i).
